// File: rtl/bnn_acc_cfu_if.sv
// CFU request/response bundle for bnn_acc_cfu: valid/ready on both directions.
// master = CPU side, slave = the CFU.
interface bnn_acc_cfu_if #(
    parameter int CFU_CFU_ID_W  = 0,
    parameter int CFU_FUNC_ID_W = 2,
    parameter int CFU_DATA_W    = 32
);
    // A zero-width id still needs one physical bit to exist as a net.
    localparam int ID_W = (CFU_CFU_ID_W > 0) ? CFU_CFU_ID_W : 1;

    logic                     req_valid;
    logic                     req_ready;
    logic [ID_W-1:0]          req_cfu;
    logic [CFU_FUNC_ID_W-1:0] req_func;
    logic [CFU_DATA_W-1:0]    req_data0;
    logic [CFU_DATA_W-1:0]    req_data1;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [2:0]               resp_status;
    logic [CFU_DATA_W-1:0]    resp_data;

    modport master (
        output req_valid, req_cfu, req_func, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_cfu, req_func, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_status, resp_data
    );
endinterface

// File: rtl/bnn_acc_cfu.sv
// bnn_acc_cfu: bit-serial popcount(xnor) CFU with signed dot product and a persistent accumulator.
// Define BNN_ACC_CFU_SATURATE_EN to clamp the accumulator (status CFU_ERROR_CUSTOM) instead of wrapping.
module bnn_acc_cfu #(
    parameter int CFU_VERSION    = 100,
    parameter int CFU_CFU_ID_MAX = 1,
    parameter int CFU_CFU_ID_W   = 0,
    parameter int CFU_FUNC_ID_W  = 2,
    parameter int CFU_DATA_W     = 32,
    parameter int CHUNK_W        = 8,
    parameter int ACC_W          = CFU_DATA_W
) (
    input logic          clk,
    input logic          rst_n,
    bnn_acc_cfu_if.slave cfu
);
    localparam int N     = CFU_DATA_W / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int SUM_W = $clog2(CFU_DATA_W) + 1;

    localparam logic [2:0] CFU_OK       = 3'd0;
    localparam logic [2:0] CFU_ERROR_OP = 3'd1;
`ifdef BNN_ACC_CFU_SATURATE_EN
    localparam logic [2:0] CFU_ERROR_CUSTOM = 3'd2;
`endif

    localparam logic [CFU_FUNC_ID_W-1:0] F_DOT   = CFU_FUNC_ID_W'(0);
    localparam logic [CFU_FUNC_ID_W-1:0] F_SDOT  = CFU_FUNC_ID_W'(1);
    localparam logic [CFU_FUNC_ID_W-1:0] F_ACC   = CFU_FUNC_ID_W'(2);
    localparam logic [CFU_FUNC_ID_W-1:0] F_RDCLR = CFU_FUNC_ID_W'(3);

    localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(N - 1);
    localparam logic signed [ACC_W:0] SDOT_OFS = (ACC_W + 1)'(CFU_DATA_W);

    if (CFU_VERSION != 100) begin : g_bad_version
        $error("bnn_acc_cfu: CFU_VERSION must be 100");
    end
    if (CFU_CFU_ID_MAX != 1 || CFU_CFU_ID_W < 0) begin : g_bad_id
        $error("bnn_acc_cfu: exactly one CFU id is served");
    end
    if (CFU_FUNC_ID_W < 2) begin : g_bad_func_w
        $error("bnn_acc_cfu: CFU_FUNC_ID_W must be >= 2");
    end
    if (CFU_DATA_W != 32 && CFU_DATA_W != 64) begin : g_bad_data_w
        $error("bnn_acc_cfu: CFU_DATA_W must be 32 or 64");
    end
    if (CHUNK_W < 1 || (CFU_DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
        $error("bnn_acc_cfu: CHUNK_W must divide CFU_DATA_W");
    end
    if (ACC_W > CFU_DATA_W || ACC_W < $clog2(CFU_DATA_W) + 2) begin : g_bad_acc_w
        $error("bnn_acc_cfu: ACC_W out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CFU_DATA_W-1:0]    r_vec;
    logic [CFU_FUNC_ID_W-1:0] r_func;
    logic [SUM_W-1:0]         r_sum;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CFU_DATA_W-1:0]    r_resp_data;
    logic [2:0]               r_resp_status;

    logic                     w_accept;
    logic                     w_is_count;
    logic                     w_req_ready;
    logic                     w_resp_valid;
    logic [SUM_W-1:0]         w_sum_nxt;
    logic signed [ACC_W:0]    w_sdot;
    logic signed [ACC_W:0]    w_acc_wide;
    logic signed [ACC_W-1:0]  w_acc_new;
    logic                     w_acc_clamp;
    logic                     w_unused_cfu;

    function automatic logic [SUM_W-1:0] popcnt_chunk(input logic [CHUNK_W-1:0] c);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            n = n + SUM_W'(c[i]);
        end
        return n;
    endfunction

    function automatic logic [CFU_DATA_W-1:0] sext_acc(input logic signed [ACC_W-1:0] x);
        return CFU_DATA_W'(x);
    endfunction

    // The SDOT magnitude never exceeds CFU_DATA_W, so narrowing the ACC_W+1 value is lossless.
    function automatic logic [CFU_DATA_W-1:0] sext_sdot(input logic signed [ACC_W:0] x);
        return CFU_DATA_W'(x);
    endfunction

`ifdef BNN_ACC_CFU_SATURATE_EN
    function automatic logic acc_ovf(input logic signed [ACC_W:0] x);
        return x[ACC_W] != x[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
        if (!acc_ovf(x)) begin
            return x[ACC_W-1:0];
        end
        return x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    assign w_acc_new   = sat_acc(w_acc_wide);
    assign w_acc_clamp = acc_ovf(w_acc_wide);
`else
    logic w_unused_wrap;
    assign w_acc_new     = w_acc_wide[ACC_W-1:0];
    assign w_acc_clamp   = 1'b0;
    assign w_unused_wrap = w_acc_wide[ACC_W];
`endif

    assign w_unused_cfu = ^cfu.req_cfu;
    assign w_is_count   = (cfu.req_func == F_DOT) || (cfu.req_func == F_SDOT) ||
                          (cfu.req_func == F_ACC);

    assign w_sum_nxt  = r_sum + popcnt_chunk(r_vec[CHUNK_W-1:0]);
    assign w_sdot     = $signed({{(ACC_W-SUM_W){1'b0}}, w_sum_nxt, 1'b0}) - SDOT_OFS;
    assign w_acc_wide = $signed({r_acc[ACC_W-1], r_acc}) + w_sdot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_req_ready = rst_n;
                w_accept    = cfu.req_valid && rst_n;
                if (w_accept) begin
                    w_state_nxt = w_is_count ? ST_COUNT : ST_RESP;
                end
            end
            ST_COUNT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_valid = rst_n;
                if (cfu.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand latch on accept, one chunk per COUNT cycle, result on the last chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vec         <= '0;
            r_func        <= '0;
            r_sum         <= '0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_resp_data   <= '0;
            r_resp_status <= CFU_OK;
        end else if (w_accept) begin
            r_func <= cfu.req_func;
            case (cfu.req_func)
                F_DOT, F_SDOT, F_ACC: begin
                    r_vec <= cfu.req_data0 ~^ cfu.req_data1;
                    r_sum <= '0;
                    r_cnt <= CNT_INIT;
                end
                F_RDCLR: begin
                    r_resp_data   <= sext_acc(r_acc);
                    r_resp_status <= CFU_OK;
                    r_acc         <= '0;
                end
                default: begin
                    r_resp_data   <= '0;
                    r_resp_status <= CFU_ERROR_OP;
                end
            endcase
        end else if (r_state == ST_COUNT) begin
            r_sum <= w_sum_nxt;
            r_vec <= r_vec >> CHUNK_W;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                case (r_func)
                    F_DOT: begin
                        r_resp_data   <= CFU_DATA_W'(w_sum_nxt);
                        r_resp_status <= CFU_OK;
                    end
                    F_SDOT: begin
                        r_resp_data   <= sext_sdot(w_sdot);
                        r_resp_status <= CFU_OK;
                    end
                    default: begin
                        r_acc         <= w_acc_new;
                        r_resp_data   <= sext_acc(w_acc_new);
`ifdef BNN_ACC_CFU_SATURATE_EN
                        r_resp_status <= w_acc_clamp ? CFU_ERROR_CUSTOM : CFU_OK;
`else
                        r_resp_status <= w_acc_clamp ? CFU_ERROR_OP : CFU_OK;
`endif
                    end
                endcase
            end
        end
    end

    assign cfu.req_ready   = w_req_ready;
    assign cfu.resp_valid  = w_resp_valid;
    assign cfu.resp_data   = r_resp_data;
    assign cfu.resp_status = r_resp_status;
endmodule

// File: tb/tb_bnn_acc_cfu.sv
// Bench for bnn_acc_cfu: fixed vector table, handshake/reset corner sequences, randomized traffic
// against an arithmetic reference model (popcount via $countones, accumulator as a plain integer).
module tb_bnn_acc_cfu;
    localparam int DW = 32;
    localparam int FW = 3;
`ifdef BNN_ACC_CFU_SATURATE_EN
    localparam int AW = 8;
`else
    localparam int AW = 32;
`endif
    localparam logic [2:0] ST_OK     = 3'd0;
    localparam logic [2:0] ST_OP     = 3'd1;
    localparam logic [2:0] ST_CUSTOM = 3'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_acc_cfu_if #(.CFU_CFU_ID_W(0), .CFU_FUNC_ID_W(FW), .CFU_DATA_W(DW)) bus ();

    bnn_acc_cfu #(
        .CFU_VERSION(100), .CFU_CFU_ID_MAX(1), .CFU_CFU_ID_W(0), .CFU_FUNC_ID_W(FW),
        .CFU_DATA_W(DW), .CHUNK_W(8), .ACC_W(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfu(bus)
    );

    int total = 0;
    int bad = 0;
    longint macc = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [2:0]  s;
        int          e;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event within bound want event", name);
    endtask

    // Reference: P from $countones, SDOT = 2P - DW, accumulator wraps or clamps at AW bits.
    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic [2:0] s, output int e);
        int     p;
        longint sd;
        longint t;
        longint lim;
        p   = $countones(~(a ^ b));
        sd  = 2 * longint'(p) - DW;
        lim = longint'(1) <<< (AW - 1);
        s   = ST_OK;
        e   = 4;
        d   = '0;
        case (f)
            3'd0: d = 32'(p);
            3'd1: d = 32'(sd);
            3'd2: begin
                t = macc + sd;
`ifdef BNN_ACC_CFU_SATURATE_EN
                if (t > lim - 1) begin
                    t = lim - 1;
                    s = ST_CUSTOM;
                end else if (t < -lim) begin
                    t = -lim;
                    s = ST_CUSTOM;
                end
`else
                t = t & (2 * lim - 1);
                if (t >= lim) t = t - 2 * lim;
`endif
                macc = t;
                d = 32'(t);
            end
            3'd3: begin
                d = 32'(macc);
                macc = 0;
                e = 0;
            end
            default: begin
                s = ST_OP;
                e = 0;
            end
        endcase
    endfunction

    // Called just after a falling edge; returns just after a falling edge with the response consumed.
    // e = rising edges between the accept edge and the edge that raised resp_valid.
    task automatic run_txn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int stall, output logic [31:0] d, output logic [2:0] s,
                           output int e);
        int n;
        d = '0;
        s = '0;
        e = -1;
        bus.req_valid = 1'b1;
        bus.req_func  = f;
        bus.req_data0 = a;
        bus.req_data1 = b;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            timed_out("accept");
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_func  = 3'($urandom);
        bus.req_data0 = $urandom;
        bus.req_data1 = $urandom;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) begin
            timed_out("resp_valid");
            return;
        end
        e = n;
        d = bus.resp_data;
        s = bus.resp_status;
        repeat (stall) @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, md, a, b;
        logic [2:0]  s, ms, f;
        int          e, me, n, r;

        bus.req_valid  = 1'b0;
        bus.req_cfu    = '0;
        bus.req_func   = '0;
        bus.req_data0  = '0;
        bus.req_data1  = '0;
        bus.resp_ready = 1'b0;

        // RDCLR responds from the accept edge itself (visible the next clock), hence e=0.
        tbl[0]  = '{3'd0, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'd16,        ST_OK, 4};
        tbl[1]  = '{3'd1, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFE0, ST_OK, 4};
        tbl[2]  = '{3'd1, 32'h1234_5678, 32'h1234_5678, 32'd32,        ST_OK, 4};
        tbl[3]  = '{3'd0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'd0,         ST_OK, 4};
        tbl[4]  = '{3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd32,        ST_OK, 4};
        tbl[5]  = '{3'd2, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'd64,        ST_OK, 4};
        tbl[6]  = '{3'd2, 32'h0000_0001, 32'h0000_0001, 32'd96,        ST_OK, 4};
        tbl[7]  = '{3'd3, 32'h1111_1111, 32'h2222_2222, 32'd96,        ST_OK, 0};
        tbl[8]  = '{3'd3, 32'h0000_0000, 32'h0000_0000, 32'd0,         ST_OK, 0};
        tbl[9]  = '{3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFE0, ST_OK, 4};
        tbl[10] = '{3'd4, 32'h1234_5678, 32'h1234_5678, 32'd0,         ST_OP, 0};
        tbl[11] = '{3'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFE0, ST_OK, 0};
        tbl[12] = '{3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         ST_OP, 0};
        tbl[13] = '{3'd3, 32'h0000_0000, 32'h0000_0000, 32'd0,         ST_OK, 0};

        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("post_rst_resp_data", 64'(bus.resp_data), 64'd0);
        check("post_rst_status", 64'(bus.resp_status), 64'(ST_OK));

        for (int i = 0; i < 14; i++) begin
            model(tbl[i].f, tbl[i].a, tbl[i].b, md, ms, me);
            run_txn(tbl[i].f, tbl[i].a, tbl[i].b, 0, d, s, e);
            check($sformatf("tbl%0d_data", i), 64'(d), 64'(tbl[i].d));
            check($sformatf("tbl%0d_status", i), 64'(s), 64'(tbl[i].s));
            check($sformatf("tbl%0d_edges", i), 64'(e), 64'(tbl[i].e));
        end

        // Stall in RESP for 10 cycles with the next request already waiting.
        bus.req_valid = 1'b1;
        bus.req_func  = 3'd0;
        bus.req_data0 = 32'h0F0F_0F0F;
        bus.req_data1 = 32'h0000_0000;
        @(posedge clk);
        @(negedge clk);
        bus.req_func  = 3'd1;
        bus.req_data0 = 32'h5555_AAAA;
        bus.req_data1 = 32'h5555_AAAA;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) timed_out("stall_resp_valid");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall%0d_valid", i), 64'(bus.resp_valid), 64'd1);
            check($sformatf("stall%0d_data", i), 64'(bus.resp_data), 64'd16);
            check($sformatf("stall%0d_req_ready", i), 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("after_hs_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("next_accepted", 64'(bus.req_ready), 64'd0);
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("next_edges", 64'(n), 64'd4);
        check("next_data", 64'(bus.resp_data), 64'd32);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;

        // Load the accumulator, then reset in the middle of a second ACC.
        run_txn(3'd2, 32'h1357_9BDF, 32'h1357_9BDF, 0, d, s, e);
        check("pre_rst_acc", 64'(d), 64'd32);
        bus.req_valid = 1'b1;
        bus.req_func  = 3'd2;
        bus.req_data0 = 32'hCAFE_F00D;
        bus.req_data1 = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        rst_n = 1'b1;
        macc = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.resp_valid) n++;
        end
        check("midrst_no_resp", 64'(n), 64'd0);
        run_txn(3'd3, 32'hFFFF_FFFF, 32'h0, 0, d, s, e);
        check("midrst_rdclr", 64'(d), 64'd0);

`ifdef BNN_ACC_CFU_SATURATE_EN
        begin
            logic [31:0] sat_d[5];
            logic [2:0]  sat_s[5];
            sat_d = '{32'd32, 32'd64, 32'd96, 32'd127, 32'd127};
            sat_s = '{ST_OK, ST_OK, ST_OK, ST_CUSTOM, ST_CUSTOM};
            for (int i = 0; i < 5; i++) begin
                model(3'd2, 32'h600D_CAFE, 32'h600D_CAFE, md, ms, me);
                run_txn(3'd2, 32'h600D_CAFE, 32'h600D_CAFE, 0, d, s, e);
                check($sformatf("sat%0d_data", i), 64'(d), 64'(sat_d[i]));
                check($sformatf("sat%0d_status", i), 64'(s), 64'(sat_s[i]));
            end
            model(3'd3, 32'h0, 32'h0, md, ms, me);
            run_txn(3'd3, 32'h0, 32'h0, 0, d, s, e);
            check("sat_rdclr", 64'(d), 64'd127);
        end
`endif

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) f = 3'(r);
            else if (r <= 5) f = 3'd2;
            else if (r == 6) f = 3'd3;
            else f = 3'($urandom_range(4, 7));
            a = $urandom;
            case ($urandom_range(0, 2))
                0: b = a;
                1: b = ~a ^ (32'd1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            model(f, a, b, md, ms, me);
            run_txn(f, a, b, $urandom_range(0, 3), d, s, e);
            check($sformatf("rnd%0d_f%0d_data", i, f), 64'(d), 64'(md));
            check($sformatf("rnd%0d_f%0d_status", i, f), 64'(s), 64'(ms));
            check($sformatf("rnd%0d_f%0d_edges", i, f), 64'(e), 64'(me));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bnn_acc_cfu.md
Name: bnn_acc_cfu

Overview:
- Sequential successor to the combinational BNN dot-product CFU.
- Computes popcount(xnor(a,b)) bit-serially, CHUNK_W bits per cycle, trading latency for popcount area.
- Adds a signed (+1/-1) dot-product mode and a persistent accumulator register for multi-word BNN layers.
- Sits behind the CPU CFU port as a CFU-L2 style unit with valid/ready handshakes on both request and response.

Parameters:
- CFU_VERSION, 100, CFU interface version; checked by check_cfu_l0_params-style elaboration check.
- CFU_CFU_ID_MAX, 1, number of CFU ids served.
- CFU_CFU_ID_W, 0, width of req_cfu.
- CFU_FUNC_ID_W, 2, width of req_func; must be >= 2.
- CFU_DATA_W, 32, operand/result width: 32 or 64.
- CHUNK_W, 8, bits counted per cycle:
  - must divide CFU_DATA_W;
  - N = CFU_DATA_W/CHUNK_W.
- ACC_W, CFU_DATA_W, accumulator width: <= CFU_DATA_W, >= $clog2(CFU_DATA_W)+2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_cfu  in  CFU_CFU_ID_W  CFU id (unused)
- req_func  in  CFU_FUNC_ID_W  function select
- req_data0  in  CFU_DATA_W  operand a
- req_data1  in  CFU_DATA_W  operand b
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_status  out  cfu_status_t  CFU_OK / CFU_ERROR_OP
- resp_data  out  CFU_DATA_W  result

Behaviour:
- Functions, with P = popcount(a ~^ b):
  - func 0 DOT: result P, zero-extended.
  - func 1 SDOT: result 2*P - CFU_DATA_W, signed, sign-extended.
  - func 2 ACC: acc <= acc + SDOT; result is the new acc, sign-extended.
  - func 3 RDCLR: result is acc, sign-extended; acc <= 0; operands ignored.
  - func >= 4 (when CFU_FUNC_ID_W > 2): resp_status = CFU_ERROR_OP, resp_data = 0, acc unchanged.
- FSM states IDLE, COUNT, RESP.
  - req_ready = (state == IDLE). Request accepted on an edge with req_valid && req_ready.
  - On accept of func 0–2: latch vec <= a ~^ b, latch func, sum <= 0, cnt <= N-1; go to COUNT.
  - COUNT, each cycle: sum += popcount(vec[CHUNK_W-1:0]); vec >>= CHUNK_W; cnt decrements. When cnt == 0, perform that final add, compute the result (and the acc update for ACC) in the same edge, and go to RESP.
  - On accept of func 3 or an illegal func: go directly to RESP. RDCLR clears acc on that accept edge.
  - RESP: resp_valid = 1. resp_data and resp_status are registered and stable until the handshake. On resp_valid && resp_ready, go to IDLE.
- Latency and throughput:
  - resp_valid rises N clocks after the accept edge for func 0–2 (N=4 at defaults); 1 clock after for func 3/illegal.
  - The earliest next accept is one clock after the response handshake. No request overlap.
  - resp_ready held low stalls indefinitely with no state change.
- Width rules:
  - sum is $clog2(CFU_DATA_W)+1 bits.
  - SDOT is computed at ACC_W+1 bits.
  - acc wraps modulo 2^ACC_W (default build).
- Reset (rst_n low at a clock edge), including mid-COUNT or mid-RESP:
  - state = IDLE, acc = 0, sum = 0, vec = 0;
  - resp_valid = 0, resp_data = 0, resp_status = CFU_OK, req_ready = 0 during reset;
  - any in-flight request is dropped with no response.
- req_cfu, and req_data0/req_data1 for RDCLR, are ignored. Inputs are sampled only at accept.

Optional Feature:
- Macro BNN_ACC_CFU_SATURATE_EN.
- Defined: ACC clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping. When a clamp occurs, resp_status = CFU_ERROR_CUSTOM, with the clamped acc value still returned and stored.
- Undefined: two's-complement wrap, with status CFU_OK.

Test Plan:
- DOT, a=32'hFFFF_0000, b=32'hFFFF_FFFF -> resp_valid 4 clocks after accept, resp_data=16, CFU_OK.
- SDOT, a=0, b=32'hFFFF_FFFF -> resp_data=32'hFFFF_FFE0 (-32); a=b=32'h1234_5678 -> 32.
- ACC three times with a=b -> responses 32, 64, 96; then RDCLR -> 96 after 1 clock; next RDCLR -> 0.
- resp_ready held low for 10 cycles in RESP -> resp_valid and resp_data stable, req_ready=0 throughout; new request accepted the cycle after the handshake.
- rst_n low during COUNT of ACC -> no response, acc=0; subsequent RDCLR returns 0.
- func=4 with CFU_FUNC_ID_W=3 -> CFU_ERROR_OP, data 0, acc unchanged. With SATURATE_EN, ACC_W=8, five ACC with a=b -> 32, 64, 96, 127 (CFU_ERROR_CUSTOM), 127 (CFU_ERROR_CUSTOM).
